// File: rtl/load_store_unit_if.sv
// CPU request/response port and data-memory port of the load/store unit.
// The slave modport is the unit itself; the master side is the CPU plus the memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_access_addr, mem_write_data, mem_write_en, mem_read
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_access_addr, mem_write_data, mem_write_en, mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// Converts byte/half/word loads and stores into word-wide memory accesses,
// using read-modify-write for sub-word stores and rejecting illegal requests.
module load_store_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0002_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    load_store_unit_if.slave         bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] addr_r;
    logic [1:0]  size_r;
    logic        we_r;
    logic        uns_r;
    logic [31:0] wdata_r;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic [31:0] mem_wdata_r;
    logic        mem_we_r;
    logic        mem_rd_r;
    logic        accept_s;
    logic        accept_err_s;

    function automatic logic request_error(input logic [1:0] size, input logic [31:0] addr);
        logic misaligned;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
        return misaligned | (addr >= ADDR_LIMIT);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic zext);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = 8'(word >> {lane, 3'b000});
        half_v = 16'(word >> {lane[1], 4'b0000});
        case (size)
            2'b00:   res = zext ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   res = zext ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of the old word; a word-size merge is a plain overwrite.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] ins;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                ins  = {24'd0, wdata[7:0]} << {lane, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                ins  = {16'd0, wdata[15:0]} << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = wdata;
            end
        endcase
        return (word & ~mask) | (ins & mask);
    endfunction

    // Request acceptance and legality of the offered request
    always_comb begin
        accept_s     = bus.req_valid & req_ready_r;
        accept_err_s = request_error(bus.req_size, bus.req_addr);
    end

    // Main control FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= 32'd0;
            size_r       <= 2'b00;
            we_r         <= 1'b0;
            uns_r        <= 1'b0;
            wdata_r      <= 32'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_wdata_r  <= 32'd0;
            mem_we_r     <= 1'b0;
            mem_rd_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r      <= bus.req_addr;
                        size_r      <= bus.req_size;
                        we_r        <= bus.req_we;
                        uns_r       <= bus.req_unsigned;
                        wdata_r     <= bus.req_wdata;
                        req_ready_r <= 1'b0;
                        if (accept_err_s) begin
                            state_r      <= ST_ERR;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                            state_r     <= ST_WR;
                            mem_we_r    <= 1'b1;
                            mem_wdata_r <= bus.req_wdata;
                        end else begin
                            state_r  <= ST_RD;
                            mem_rd_r <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    mem_rd_r <= 1'b0;
                    if (we_r) begin
                        state_r     <= ST_WR;
                        mem_we_r    <= 1'b1;
                        mem_wdata_r <= store_merge(bus.mem_read_data, size_r, addr_r[1:0], wdata_r);
                    end else begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= load_extend(bus.mem_read_data, size_r, addr_r[1:0], uns_r);
                    end
                end
                ST_WR: begin
                    state_r      <= ST_RESP;
                    mem_we_r     <= 1'b0;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'd0;
                end
                ST_RESP, ST_ERR: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    mem_we_r     <= 1'b0;
                    mem_rd_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_r;
    assign bus.resp_valid      = resp_valid_r;
    assign bus.resp_err        = resp_err_r;
    assign bus.resp_rdata      = resp_rdata_r;
    assign bus.mem_access_addr = {addr_r[31:2], 2'b00};
    assign bus.mem_write_data  = mem_wdata_r;
    assign bus.mem_write_en    = mem_we_r;
    assign bus.mem_read        = mem_rd_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: a byte-level reference memory predicts each response,
// a separate monitor compares every DUT response, latency and memory pulse count.
module tb_load_store_unit;

    localparam logic [31:0] LIMIT = 32'h0002_0000;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd_pulses;
        int          wr_pulses;
        int          acc_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;
    int          cyc;
    int          rd_seen;
    int          wr_seen;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [7:0]  ref_bytes [0:131071];
    logic [31:0] phys_mem [0:32767];
    logic        pre_en;
    logic [14:0] pre_idx;
    logic [31:0] pre_data;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cycle counter used to measure response latency
    always @(posedge clk) cyc <= cyc + 1;

    // word-wide data memory seen by the DUT, plus a bench-only preload path
    always @(posedge clk) begin
        if (pre_en) phys_mem[pre_idx] <= pre_data;
        else if (bus.mem_write_en) phys_mem[bus.mem_access_addr[16:2]] <= bus.mem_write_data;
    end
    assign bus.mem_read_data = phys_mem[bus.mem_access_addr[16:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: counts memory pulses and compares each response with the scoreboard head
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_seen = 0;
            wr_seen = 0;
        end else begin
            if (bus.mem_read) rd_seen++;
            if (bus.mem_write_en) wr_seen++;
            if (bus.resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, mon_e.err});
                    chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
                    chk("latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
                    chk("mem_read_pulses", 32'(rd_seen), 32'(mon_e.rd_pulses));
                    chk("mem_write_pulses", 32'(wr_seen), 32'(mon_e.wr_pulses));
                end
                rd_seen = 0;
                wr_seen = 0;
            end
        end
    end

    function automatic logic ref_error(input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        if (size == 2'd3) return 1'b1;
        nbytes = 1 << size;
        if ((addr % nbytes) != 0) return 1'b1;
        return addr >= LIMIT;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_idx  = addr[16:2];
        pre_data = data;
        for (int i = 0; i < 4; i++) ref_bytes[int'({addr[16:2], 2'b00}) + i] = data[8*i +: 8];
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) return;
        end
        chk("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          n;
        logic [31:0] v;
        wait_ready();
        drive(we, size, uns, addr, wdata);
        n = 1 << size;
        e.err = ref_error(size, addr);
        e.acc_cyc = cyc;
        if (e.err) begin
            e.rdata = 32'd0; e.lat = 1; e.rd_pulses = 0; e.wr_pulses = 0;
        end else if (we) begin
            e.rdata = 32'd0;
            e.lat = (n == 4) ? 2 : 3;
            e.rd_pulses = (n == 4) ? 0 : 1;
            e.wr_pulses = 1;
            for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v; e.lat = 2; e.rd_pulses = 1; e.wr_pulses = 0;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) return;
        end
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic check_mem(input string name, input logic [31:0] addr, input logic [31:0] exp);
        drain();
        @(negedge clk);
        chk(name, phys_mem[addr[16:2]], exp);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        chk("rst_mem_write_en", {31'd0, bus.mem_write_en}, 32'd0);
        chk("rst_mem_access_addr", bus.mem_access_addr, 32'd0);
        chk("rst_mem_write_data", bus.mem_write_data, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        int          r;
        checks = 0; errors = 0; cyc = 0; rd_seen = 0; wr_seen = 0;
        pre_en = 1'b0; pre_idx = 15'd0; pre_data = 32'd0;
        for (int i = 0; i < 131072; i++) ref_bytes[i] = 8'd0;
        rst_n = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);

        // request held during reset must be ignored; preload memory meanwhile
        for (int w = 0; w < 64; w++) preload(32'(w * 4), $urandom);
        for (int w = 0; w < 4; w++) preload(32'h0001_FFF0 + 32'(w * 4), $urandom);
        @(negedge clk);
        check_reset_outputs();
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'd0, bus.req_ready}, 32'd1);

        // word store then word load
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678);
        check_mem("mem_word_store", 32'h10, 32'h1234_5678);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0);

        // byte read-modify-write and byte loads
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00AB);
        check_mem("mem_byte_rmw", 32'h10, 32'hAB34_5678);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'd0);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'd0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'd0);

        // halfword store/load and misaligned rejects
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_8001);
        check_mem("mem_half_rmw", 32'h10, 32'h8001_5678);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'd0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'd0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h5555_5555);
        check_mem("mem_after_reject", 32'h10, 32'h8001_5678);

        // address range boundary and illegal size
        issue(1'b0, 2'b10, 1'b0, 32'h0001_FFFC, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h0002_0000, 32'd0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'd0);
        drain();

        // reset during the write phase of a byte store aborts it
        preload(32'h0000_0020, 32'hCAFE_BABE);
        wait_ready();
        drive(1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h0000_00EE);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_write_en) break;
        end
        chk("abort_reached_wr", {31'd0, bus.mem_write_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we_drop", {31'd0, bus.mem_write_en}, 32'd0);
        chk("abort_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_mem_unchanged", phys_mem[15'd8], 32'hCAFE_BABE);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0);
        drain();

        // randomized traffic
        for (int t = 0; t < 250; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) addr = 32'($urandom_range(0, 255));
            else if (r == 8) addr = 32'h0001_FFF0 + 32'($urandom_range(0, 15));
            else addr = LIMIT + 32'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  addr, $urandom);
        end
        drain();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
